// File: rtl/sobel_window_engine.sv
// Sobel edge engine: takes a 4x4 window, emits |Gx|+|Gy| (gain-scaled or thresholded)
// for the four interior pixels in raster order. Define SOBEL_SAT_COUNT_EN to add sat_count.
module sobel_window_engine #(
  parameter int PIXEL_W    = 4,
  parameter int OUT_W      = 4,
  parameter int GAIN_W     = 4,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         bus_data_ready,
  input  logic                         mode,
  input  logic [GAIN_W-1:0]            brightness_value,
  input  logic [OUT_W-1:0]             threshold,
  input  logic [3:0][3:0][PIXEL_W-1:0] input_pixels,
  output logic [OUT_W-1:0]             output_pixel,
  output logic                         output_enable,
`ifdef SOBEL_SAT_COUNT_EN
  output logic [15:0]                  sat_count,
`endif
  output logic                         need_data
);

  localparam int GW = PIXEL_W + 4;
  localparam int MW = GW + GAIN_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state_q;
  logic [1:0]                   pos_q;
  logic [3:0][3:0][PIXEL_W-1:0] win_q;
  logic                         mode_q, mode_s1_q;
  logic [GAIN_W-1:0]            gain_q, gain_s1_q;
  logic [OUT_W-1:0]             thr_q, thr_s1_q;
  logic [1:0]                   vld_pipe_q;
  logic signed [GW-1:0]         gx_d, gy_d, gx_q, gy_q;
  logic [OUT_W-1:0]             pix_d, pix_q;
  logic                         over_d;
  logic                         accept;

  assign need_data     = (state_q == IDLE) || ((state_q == RUN) && (pos_q == 2'd3));
  assign accept        = bus_data_ready && need_data;
  assign output_pixel  = pix_q;
  assign output_enable = vld_pipe_q[1];

  // 3x3 neighbourhood around the interior position selected by pos_q (row = pos[1], col = pos[0])
  logic signed [GW-1:0] nb [3][3];
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        nb[i][j] = signed'({4'b0, win_q[2'(i) + {1'b0, pos_q[1]}][2'(j) + {1'b0, pos_q[0]}]});
    gx_d = (nb[0][2] + (nb[1][2] <<< 1) + nb[2][2]) - (nb[0][0] + (nb[1][0] <<< 1) + nb[2][0]);
    gy_d = (nb[2][0] + (nb[2][1] <<< 1) + nb[2][2]) - (nb[0][0] + (nb[0][1] <<< 1) + nb[0][2]);
  end

  logic [GW-1:0]    ax, ay, mag;
  logic [MW-1:0]    scaled;
  logic [OUT_W-1:0] sat;
  always_comb begin
    ax     = gx_q[GW-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
    ay     = gy_q[GW-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
    mag    = ax + ay;
    scaled = (MW'(mag) * MW'(gain_s1_q)) >> GAIN_SHIFT;
    over_d = scaled > MW'({OUT_W{1'b1}});
    sat    = over_d ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
    pix_d  = mode_s1_q ? ((sat >= thr_s1_q) ? {OUT_W{1'b1}} : '0) : sat;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      win_q      <= '0;
      mode_q     <= 1'b0;
      gain_q     <= '0;
      thr_q      <= '0;
      vld_pipe_q <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
      mode_s1_q  <= 1'b0;
      gain_s1_q  <= '0;
      thr_s1_q   <= '0;
      pix_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], state_q == RUN};
      // Controls travel with the data so a back-to-back accept cannot disturb the tail of the previous window
      if (state_q == RUN) begin
        gx_q      <= gx_d;
        gy_q      <= gy_d;
        mode_s1_q <= mode_q;
        gain_s1_q <= gain_q;
        thr_s1_q  <= thr_q;
      end
      if (vld_pipe_q[0]) pix_q <= pix_d;
      if (accept) begin
        state_q <= RUN;
        pos_q   <= '0;
        win_q   <= input_pixels;
        mode_q  <= mode;
        gain_q  <= brightness_value;
        thr_q   <= threshold;
      end else if (state_q == RUN) begin
        if (pos_q == 2'd3) state_q <= IDLE;
        pos_q <= pos_q + 2'd1;
      end
    end
  end

`ifdef SOBEL_SAT_COUNT_EN
  logic [15:0] sat_cnt_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                     sat_cnt_q <= '0;
    else if (vld_pipe_q[0] && over_d) sat_cnt_q <= sat_cnt_q + 16'd1;
  end
  assign sat_count = sat_cnt_q;
`endif

endmodule
